// File: rtl/axi_mem_responder_pkg.sv
// Shared types and constants for the AXI4 memory responder and its address generator.
package axi_mem_responder_pkg;

    localparam int unsigned AXI_ADDR_W = 64;
    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_USER_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [5:0]            atop;
    } axi_mem_aw_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_mem_ar_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0]   data;
        logic [AXI_DATA_W/8-1:0] strb;
        logic                    last;
    } axi_mem_w_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0] id;
        logic [1:0]          resp;
    } axi_mem_b_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [AXI_USER_W-1:0] user;
    } axi_mem_r_t;

    typedef struct packed {
        axi_mem_aw_t aw;
        logic        aw_valid;
        axi_mem_w_t  w;
        logic        w_valid;
        logic        b_ready;
        axi_mem_ar_t ar;
        logic        ar_valid;
        logic        r_ready;
    } axi_mem_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        axi_mem_b_t  b;
        logic        b_valid;
        logic        ar_ready;
        axi_mem_r_t  r;
        logic        r_valid;
    } axi_mem_rsp_t;

    // The memory is 64 bits wide, so any beat size above 8 bytes behaves as 8 bytes.
    function automatic logic [2:0] effSize(input logic [2:0] size);
        return (size > 3'd3) ? 3'd3 : size;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP AXI bursts.
module axi_burst_addr_gen
    import axi_mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [7:0]           i_len,
    input  logic [2:0]           i_size,
    input  logic [1:0]           i_burst,
    output logic [AddrWidth-1:0] o_nextAddr
);

    logic [AddrWidth-1:0] w_step;
    logic [AddrWidth-1:0] w_wrapMask;
    logic [AddrWidth-1:0] w_incAddr;

    assign w_step     = AddrWidth'(1) << effSize(i_size);
    assign w_wrapMask = ((AddrWidth'(i_len) + AddrWidth'(1)) << effSize(i_size)) - AddrWidth'(1);
    assign w_incAddr  = i_addr + w_step;

    // WRAP keeps the bits above the wrap window and lets the low bits roll over inside it.
    always_comb begin
        unique case (i_burst)
            BURST_FIXED: o_nextAddr = i_addr;
            BURST_WRAP:  o_nextAddr = (i_addr & ~w_wrapMask) | (w_incAddr & w_wrapMask);
            default:     o_nextAddr = w_incAddr;
        endcase
    end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a local word-addressed memory; independent read and write FSMs.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiUserWidth = 32,
    parameter int unsigned MemWords     = 1024,
    parameter logic [AxiAddrWidth-1:0] BaseAddr = 64'h8000_0000,
    parameter type axi_req_t = axi_mem_req_t,
    parameter type axi_rsp_t = axi_mem_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);

    if (AxiDataWidth != 64 || AxiAddrWidth != AXI_ADDR_W || AxiIdWidth != AXI_ID_W ||
        AxiUserWidth != AXI_USER_W) begin : gen_badWidth
        $error("axi_mem_responder: unsupported AXI widths");
    end

    localparam int unsigned IdxW = $clog2(MemWords);
    localparam logic [AxiAddrWidth-1:0] MemBytes = AxiAddrWidth'(MemWords) << 3;

    // Unsigned offset compare covers both the below-base and above-top cases.
    function automatic logic inRange(input logic [AxiAddrWidth-1:0] a);
        return (a - BaseAddr) < MemBytes;
    endfunction

    function automatic logic [IdxW-1:0] wordIdx(input logic [AxiAddrWidth-1:0] a);
        return IdxW'((a - BaseAddr) >> 3);
    endfunction

    w_state_e               r_wState, w_wNext;
    logic [AxiIdWidth-1:0]  r_wId;
    logic [AxiAddrWidth-1:0] r_wAddr, w_wAddrNext;
    logic [7:0]             r_wLen;
    logic [2:0]             r_wSize;
    logic [1:0]             r_wBurst;
    logic                   r_wAtomic, r_wDecErr;
    logic                   w_awReady, w_wReady, w_bValid, w_awHs, w_wHs;
    logic                   w_wInRange, w_memWe;
    logic [IdxW-1:0]        w_wIdx;
    logic [AxiDataWidth-1:0] w_wrData;

    r_state_e               r_rState, w_rNext;
    logic [AxiIdWidth-1:0]  r_rId;
    logic [AxiAddrWidth-1:0] r_rAddr, w_rAddrNext;
    logic [7:0]             r_rLen, r_rCnt;
    logic [2:0]             r_rSize;
    logic [1:0]             r_rBurst;
    logic                   w_arReady, w_rValid, w_arHs, w_rHs, w_rLast, w_rInRange;
    logic [AxiDataWidth-1:0] w_rData;

    logic [AxiDataWidth-1:0] w_memRd [MemWords];

    axi_burst_addr_gen #(.AddrWidth(AxiAddrWidth)) u_wAddrGen (
        .i_addr     (r_wAddr),
        .i_len      (r_wLen),
        .i_size     (r_wSize),
        .i_burst    (r_wBurst),
        .o_nextAddr (w_wAddrNext)
    );

    axi_burst_addr_gen #(.AddrWidth(AxiAddrWidth)) u_rAddrGen (
        .i_addr     (r_rAddr),
        .i_len      (r_rLen),
        .i_size     (r_rSize),
        .i_burst    (r_rBurst),
        .o_nextAddr (w_rAddrNext)
    );

    assign w_awHs     = axi_req_i.aw_valid && w_awReady;
    assign w_wHs      = axi_req_i.w_valid && w_wReady;
    assign w_wInRange = inRange(r_wAddr);
    assign w_wIdx     = wordIdx(r_wAddr);
    assign w_memWe    = w_wHs && !r_wAtomic && w_wInRange;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_wState <= W_IDLE;
        else         r_wState <= w_wNext;
    end

    always_comb begin
        w_wNext = r_wState;
        unique case (r_wState)
            W_IDLE:  if (w_awHs) w_wNext = W_DATA;
            W_DATA:  if (w_wHs && axi_req_i.w.last) w_wNext = W_RESP;
            W_RESP:  if (axi_req_i.b_ready) w_wNext = W_IDLE;
            default: w_wNext = W_IDLE;
        endcase
    end

    // Ready lines are held low during reset even though the state register already reads IDLE.
    always_comb begin
        w_awReady = 1'b0;
        w_wReady  = 1'b0;
        w_bValid  = 1'b0;
        unique case (r_wState)
            W_IDLE:  w_awReady = rst_ni;
            W_DATA:  w_wReady  = rst_ni;
            W_RESP:  w_bValid  = rst_ni;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wId     <= '0;
            r_wAddr   <= '0;
            r_wLen    <= '0;
            r_wSize   <= '0;
            r_wBurst  <= '0;
            r_wAtomic <= 1'b0;
            r_wDecErr <= 1'b0;
        end else if (w_awHs) begin
            r_wId     <= axi_req_i.aw.id;
            r_wAddr   <= axi_req_i.aw.addr;
            r_wLen    <= axi_req_i.aw.len;
            r_wSize   <= axi_req_i.aw.size;
            r_wBurst  <= axi_req_i.aw.burst;
            r_wAtomic <= (axi_req_i.aw.atop != '0);
            r_wDecErr <= 1'b0;
        end else if (w_wHs) begin
            r_wAddr <= w_wAddrNext;
            if (!w_wInRange) r_wDecErr <= 1'b1;
        end
    end

    always_comb begin
        w_wrData = w_memRd[w_wIdx];
        for (int b = 0; b < AxiDataWidth / 8; b++) begin
            if (axi_req_i.w.strb[b]) w_wrData[b*8 +: 8] = axi_req_i.w.data[b*8 +: 8];
        end
    end

    // One register per word keeps the reset clear and the byte merge free of array-wide loops.
    for (genvar gi = 0; gi < MemWords; gi++) begin : gen_mem
        logic [AxiDataWidth-1:0] r_word;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)                                r_word <= '0;
            else if (w_memWe && w_wIdx == IdxW'(gi))    r_word <= w_wrData;
        end
        assign w_memRd[gi] = r_word;
    end

    assign w_arHs     = axi_req_i.ar_valid && w_arReady;
    assign w_rHs      = w_rValid && axi_req_i.r_ready;
    assign w_rLast    = (r_rCnt == r_rLen);
    assign w_rInRange = inRange(r_rAddr);
    assign w_rData    = w_rInRange ? w_memRd[wordIdx(r_rAddr)] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rState <= R_IDLE;
        else         r_rState <= w_rNext;
    end

    always_comb begin
        w_rNext = r_rState;
        unique case (r_rState)
            R_IDLE:  if (w_arHs) w_rNext = R_DATA;
            R_DATA:  if (w_rHs && w_rLast) w_rNext = R_IDLE;
            default: w_rNext = R_IDLE;
        endcase
    end

    always_comb begin
        w_arReady = (r_rState == R_IDLE) && rst_ni;
        w_rValid  = (r_rState == R_DATA);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rId    <= '0;
            r_rAddr  <= '0;
            r_rLen   <= '0;
            r_rSize  <= '0;
            r_rBurst <= '0;
            r_rCnt   <= '0;
        end else if (w_arHs) begin
            r_rId    <= axi_req_i.ar.id;
            r_rAddr  <= axi_req_i.ar.addr;
            r_rLen   <= axi_req_i.ar.len;
            r_rSize  <= axi_req_i.ar.size;
            r_rBurst <= axi_req_i.ar.burst;
            r_rCnt   <= '0;
        end else if (w_rHs) begin
            r_rAddr <= w_rAddrNext;
            r_rCnt  <= r_rCnt + 8'd1;
        end
    end

    // Payloads are zeroed whenever their valid is low, so reset shows clean channels.
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = w_awReady;
        axi_rsp_o.w_ready  = w_wReady;
        axi_rsp_o.b_valid  = w_bValid;
        axi_rsp_o.ar_ready = w_arReady;
        axi_rsp_o.r_valid  = w_rValid;
        if (w_bValid) begin
            axi_rsp_o.b.id   = r_wId;
            axi_rsp_o.b.resp = r_wAtomic ? RESP_SLVERR : (r_wDecErr ? RESP_DECERR : RESP_OKAY);
        end
        if (w_rValid) begin
            axi_rsp_o.r.id   = r_rId;
            axi_rsp_o.r.data = w_rData;
            axi_rsp_o.r.resp = w_rInRange ? RESP_OKAY : RESP_DECERR;
            axi_rsp_o.r.last = w_rLast;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized scoreboard bench for axi_mem_responder against a byte-level memory model.
module tb_axi_mem_responder;
    import axi_mem_responder_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          WORDS = 1024;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } expB_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } expR_t;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    axi_mem_req_t req;
    axi_mem_rsp_t rsp;

    int    errors = 0;
    int    checks = 0;
    logic [63:0] model [WORDS];
    expB_t bq[$];
    expR_t rq[$];
    bit    toggleRReady = 1'b0;

    axi_mem_responder dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .axi_req_i (req),
        .axi_rsp_o (rsp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat address from the burst definition: start plus i steps, folded into the wrap window.
    function automatic logic [63:0] beatAddr(input logic [63:0] a, input int len, input int size,
                                             input logic [1:0] burst, input int i);
        logic [63:0] step, total, lo;
        step  = 64'd1 << size;
        total = 64'(len + 1) * step;
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP: begin
                lo = a - (a % total);
                return lo + ((a - lo + 64'(i) * step) % total);
            end
            default: return a + 64'(i) * step;
        endcase
    endfunction

    function automatic bit inMem(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(8 * WORDS));
    endfunction

    task automatic writeBurst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [5:0] atop,
                              input logic [63:0] data [16], input logic [7:0] strb [16]);
        bit    dec = 1'b0;
        int    t;
        int    idx;
        logic [63:0] a;
        expB_t e;
        for (int i = 0; i <= int'(len); i++) begin
            a = beatAddr(addr, int'(len), int'(size), burst, i);
            if (!inMem(a)) dec = 1'b1;
            else if (atop == 6'd0) begin
                idx = int'((a - BASE) >> 3);
                for (int b = 0; b < 8; b++)
                    if (strb[i][b]) model[idx][b*8 +: 8] = data[i][b*8 +: 8];
            end
        end
        e.id   = id;
        e.resp = (atop != 6'd0) ? RESP_SLVERR : (dec ? RESP_DECERR : RESP_OKAY);
        bq.push_back(e);

        @(posedge clk); #1;
        req.aw.id = id; req.aw.addr = addr; req.aw.len = len;
        req.aw.size = size; req.aw.burst = burst; req.aw.atop = atop;
        req.aw_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rsp.aw_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) checkOutput("aw_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req.aw_valid = 1'b0;

        for (int i = 0; i <= int'(len); i++) begin
            req.w.data = data[i]; req.w.strb = strb[i]; req.w.last = (i == int'(len));
            req.w_valid = 1'b1;
            t = 0;
            @(negedge clk);
            if (i == 0) checkOutput("w_ready_latency", 64'(rsp.w_ready), 64'd1);
            while (!rsp.w_ready && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) checkOutput("w_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        @(negedge clk);
        checkOutput("b_latency", 64'(rsp.b_valid), 64'd1);
        t = 0;
        while (bq.size() != 0 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) checkOutput("b_timeout", 64'd0, 64'd1);
    endtask

    task automatic readBurst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        int    t;
        logic [63:0] a;
        expR_t e;
        for (int i = 0; i <= int'(len); i++) begin
            a      = beatAddr(addr, int'(len), int'(size), burst, i);
            e.id   = id;
            e.data = inMem(a) ? model[int'((a - BASE) >> 3)] : 64'd0;
            e.resp = inMem(a) ? RESP_OKAY : RESP_DECERR;
            e.last = (i == int'(len));
            rq.push_back(e);
        end

        @(posedge clk); #1;
        req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
        req.ar.size = size; req.ar.burst = burst;
        req.ar_valid = 1'b1;
        req.r_ready  = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rsp.ar_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) checkOutput("ar_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        checkOutput("r_valid_latency", 64'(rsp.r_valid), 64'd1);
        t = 0;
        while (rq.size() != 0 && t < 200) begin
            @(posedge clk); #1;
            req.r_ready = toggleRReady ? ~req.r_ready : 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 200) checkOutput("r_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req.r_ready = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every B/R handshake and checks R holds while stalled.
    initial begin
        axi_mem_rsp_t prev;
        bit           prevStall;
        expB_t        eb;
        expR_t        er;
        prevStall = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                prevStall = 1'b0;
                continue;
            end
            if (prevStall) begin
                checkOutput("r_hold_valid", 64'(rsp.r_valid), 64'd1);
                checkOutput("r_hold_data", rsp.r.data, prev.r.data);
            end
            if (rsp.b_valid && req.b_ready) begin
                if (bq.size() == 0) checkOutput("unexpected_b", 64'd1, 64'd0);
                else begin
                    eb = bq.pop_front();
                    checkOutput("b_resp", 64'(rsp.b.resp), 64'(eb.resp));
                    checkOutput("b_id", 64'(rsp.b.id), 64'(eb.id));
                end
            end
            if (rsp.r_valid && req.r_ready) begin
                if (rq.size() == 0) checkOutput("unexpected_r", 64'd1, 64'd0);
                else begin
                    er = rq.pop_front();
                    checkOutput("r_data", rsp.r.data, er.data);
                    checkOutput("r_resp", 64'(rsp.r.resp), 64'(er.resp));
                    checkOutput("r_last", 64'(rsp.r.last), 64'(er.last));
                    checkOutput("r_id", 64'(rsp.r.id), 64'(er.id));
                end
            end
            prevStall = rsp.r_valid && !req.r_ready;
            prev      = rsp;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input int count);
        logic [63:0] d [16];
        logic [7:0]  s [16];
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        for (int n = 0; n < count; n++) begin
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 2));
            if (burst == BURST_WRAP) len = 8'((2 << $urandom_range(0, 3)) - 1);
            else                     len = 8'($urandom_range(0, 7));
            addr = BASE + 64'($urandom_range(0, WORDS + 3)) * 64'd8
                 + (64'($urandom_range(0, 7)) & ~((64'd1 << size) - 64'd1));
            for (int i = 0; i < 16; i++) begin
                d[i] = {$urandom, $urandom};
                s[i] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 0) writeBurst(4'($urandom), addr, len, size, burst, 6'd0, d, s);
            else                           readBurst(4'($urandom), addr, len, size, burst);
        end
    endtask

    initial begin
        logic [63:0] d [16];
        logic [7:0]  s [16];
        int t;

        req = '0;
        for (int i = 0; i < WORDS; i++) model[i] = 64'd0;
        for (int i = 0; i < 16; i++) begin d[i] = 64'd0; s[i] = 8'hFF; end

        #1;
        checkOutput("reset_aw_ready", 64'(rsp.aw_ready), 64'd0);
        checkOutput("reset_ar_ready", 64'(rsp.ar_ready), 64'd0);
        checkOutput("reset_b_valid", 64'(rsp.b_valid), 64'd0);
        checkOutput("reset_r_valid", 64'(rsp.r_valid), 64'd0);
        checkOutput("reset_r_data", rsp.r.data, 64'd0);
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        #1;
        checkOutput("aw_ready_after_reset", 64'(rsp.aw_ready), 64'd1);
        checkOutput("ar_ready_after_reset", 64'(rsp.ar_ready), 64'd1);

        $display("[TB] partial strobe write over zeros");
        d[0] = 64'hAAAA_BBBB_CCCC_DDDD; s[0] = 8'h0F;
        writeBurst(4'd1, BASE + 64'h10, 8'd0, 3'd3, BURST_INCR, 6'd0, d, s);
        readBurst(4'd2, BASE + 64'h10, 8'd0, 3'd3, BURST_INCR);

        $display("[TB] INCR burst write and read back");
        d[0] = 64'h1111_1111_1111_1111; d[1] = 64'h2222_2222_2222_2222;
        d[2] = 64'h3333_3333_3333_3333; d[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) s[i] = 8'hFF;
        writeBurst(4'd3, BASE, 8'd3, 3'd3, BURST_INCR, 6'd0, d, s);
        readBurst(4'd4, BASE, 8'd3, 3'd3, BURST_INCR);

        $display("[TB] WRAP read starting mid-window");
        readBurst(4'd5, BASE + 64'h18, 8'd3, 3'd3, BURST_WRAP);

        $display("[TB] out-of-range read and write");
        readBurst(4'd6, BASE + 64'h2000, 8'd0, 3'd3, BURST_INCR);
        d[0] = 64'hDEAD_BEEF_DEAD_BEEF; s[0] = 8'hFF;
        writeBurst(4'd7, BASE + 64'h2000, 8'd0, 3'd3, BURST_INCR, 6'd0, d, s);
        writeBurst(4'd8, BASE + 64'h1FF8, 8'd1, 3'd3, BURST_INCR, 6'd0, d, s);
        readBurst(4'd9, BASE + 64'h1FF8, 8'd1, 3'd3, BURST_INCR);

        $display("[TB] atomic write is refused");
        d[0] = 64'h0123_4567_89AB_CDEF;
        writeBurst(4'd10, BASE + 64'h40, 8'd0, 3'd3, BURST_INCR, 6'h20, d, s);
        readBurst(4'd11, BASE + 64'h40, 8'd0, 3'd3, BURST_INCR);

        $display("[TB] concurrent read with stalls and write");
        for (int i = 0; i < 16; i++) d[i] = {$urandom, $urandom};
        toggleRReady = 1'b1;
        fork
            readBurst(4'd12, BASE, 8'd7, 3'd3, BURST_INCR);
            writeBurst(4'd13, BASE + 64'h100, 8'd3, 3'd3, BURST_INCR, 6'd0, d, s);
        join
        toggleRReady = 1'b0;

        $display("[TB] randomized traffic");
        applyStimulus(40);

        $display("[TB] reset in the middle of a read burst");
        @(posedge clk); #1;
        req.r_ready = 1'b0;
        req.ar.id = 4'd14; req.ar.addr = BASE; req.ar.len = 8'd7;
        req.ar.size = 3'd3; req.ar.burst = BURST_INCR;
        req.ar_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!rsp.ar_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) checkOutput("ar_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req.ar_valid = 1'b0;
        @(negedge clk);
        checkOutput("r_valid_before_reset", 64'(rsp.r_valid), 64'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("r_valid_in_reset", 64'(rsp.r_valid), 64'd0);
        checkOutput("ar_ready_in_reset", 64'(rsp.ar_ready), 64'd0);
        checkOutput("aw_ready_in_reset", 64'(rsp.aw_ready), 64'd0);
        for (int i = 0; i < WORDS; i++) model[i] = 64'd0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        req.r_ready = 1'b1;
        #1;
        checkOutput("ar_ready_after_release", 64'(rsp.ar_ready), 64'd1);
        readBurst(4'd15, BASE, 8'd3, 3'd3, BURST_INCR);

        repeat (5) @(posedge clk);
        checkOutput("b_queue_drained", 64'(bq.size()), 64'd0);
        checkOutput("r_queue_drained", 64'(rq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
